// File: rtl/soil_moisture_scan_ctrl.sv
// rtl/soil_moisture_scan_ctrl.sv - soil moisture zone scanner with per-zone pump control
//
// Purpose:
//   On start, walks zones 0..N_ZONES-1. For each zone it requests one ADC
//   conversion, waits up to ADC_TIMEOUT cycles for adc_done, then drives
//   that zone's pump from the captured sample. A zone whose ADC never
//   answers is flagged in fault and its pump is switched off.
//
// Optional feature macro:
//   MOISTURE_HYST_EN - pump on below th_low, off at/above th_high, hold between.
//                      Undefined: pump_en[zone] = (sample < th_low), th_high unused.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   begin one full scan (honoured only in IDLE)
//   adc_req    out  one-cycle conversion request (first MEASURE cycle)
//   adc_ch     out  zone being measured
//   adc_done   in   conversion complete, adc_data valid same cycle
//   adc_data   in   moisture sample, larger = wetter
//   th_low     in   dry threshold
//   th_high    in   wet threshold (hysteresis build only)
//   pump_en    out  per-zone pump drive
//   fault      out  per-zone ADC timeout flag
//   busy       out  scan in progress
//   scan_done  out  one-cycle pulse when the scan finishes

module soil_moisture_scan_ctrl #(
    parameter int N_ZONES     = 4,
    parameter int ADC_W       = 10,
    parameter int ADC_TIMEOUT = 255,
    localparam int ZW         = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               adc_req,
    output logic [ZW-1:0]      adc_ch,
    input  logic               adc_done,
    input  logic [ADC_W-1:0]   adc_data,
    input  logic [ADC_W-1:0]   th_low,
    input  logic [ADC_W-1:0]   th_high,
    output logic [N_ZONES-1:0] pump_en,
    output logic [N_ZONES-1:0] fault,
    output logic               busy,
    output logic               scan_done
);

    localparam int CW = $clog2(ADC_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_MEASURE = 2'b01;
    localparam logic [1:0] S_CONTROL = 2'b10;

    localparam logic [ZW-1:0] LAST_ZONE = ZW'(N_ZONES - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(ADC_TIMEOUT - 1);

    logic [1:0]         state_q,     state_d;
    logic [ZW-1:0]      zone_q,      zone_d;
    logic [CW-1:0]      cnt_q,       cnt_d;
    logic [ADC_W-1:0]   sample_q,    sample_d;
    logic [N_ZONES-1:0] pump_en_q,   pump_en_d;
    logic [N_ZONES-1:0] fault_q,     fault_d;
    logic               scan_done_q, scan_done_d;
    logic               pump_next;

    // Pump decision for the current zone from the captured sample.
`ifdef MOISTURE_HYST_EN
    always_comb begin
        pump_next = pump_en_q[zone_q];
        if (sample_q < th_low) begin
            pump_next = 1'b1;
        end else if (sample_q >= th_high) begin
            pump_next = 1'b0;
        end
    end
`else
    logic unused_th_high;
    assign unused_th_high = ^th_high;

    always_comb begin
        pump_next = (sample_q < th_low);
    end
`endif

    always_comb begin
        state_d     = state_q;
        zone_d      = zone_q;
        cnt_d       = cnt_q;
        sample_d    = sample_q;
        pump_en_d   = pump_en_q;
        fault_d     = fault_q;
        scan_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MEASURE;
                    zone_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_MEASURE: begin
                if (adc_done) begin
                    // A done arriving in the timeout cycle still counts.
                    sample_d = adc_data;
                    state_d  = S_CONTROL;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d[zone_q]   = 1'b1;
                    pump_en_d[zone_q] = 1'b0;
                    cnt_d             = '0;
                    if (zone_q == LAST_ZONE) begin
                        state_d     = S_IDLE;
                        zone_d      = '0;
                        scan_done_d = 1'b1;
                    end else begin
                        // Stay in MEASURE; cleared counter re-fires adc_req.
                        zone_d = zone_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CONTROL: begin
                pump_en_d[zone_q] = pump_next;
                fault_d[zone_q]   = 1'b0;
                cnt_d             = '0;
                if (zone_q == LAST_ZONE) begin
                    state_d     = S_IDLE;
                    zone_d      = '0;
                    scan_done_d = 1'b1;
                end else begin
                    state_d = S_MEASURE;
                    zone_d  = zone_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            zone_q      <= '0;
            cnt_q       <= '0;
            sample_q    <= '0;
            pump_en_q   <= '0;
            fault_q     <= '0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zone_q      <= zone_d;
            cnt_q       <= cnt_d;
            sample_q    <= sample_d;
            pump_en_q   <= pump_en_d;
            fault_q     <= fault_d;
            scan_done_q <= scan_done_d;
        end
    end

    // Counter is cleared on every MEASURE entry, so zero marks the first cycle.
    assign adc_req   = (state_q == S_MEASURE) && (cnt_q == '0);
    assign adc_ch    = zone_q;
    assign pump_en   = pump_en_q;
    assign fault     = fault_q;
    assign busy      = (state_q != S_IDLE);
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_soil_moisture_scan_ctrl.sv
// tb/tb_soil_moisture_scan_ctrl.sv - self-checking bench for soil_moisture_scan_ctrl
module tb_soil_moisture_scan_ctrl;

    localparam int NZ = 4;
    localparam int AW = 10;
    localparam int TO = 6;
    localparam int ZW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          adc_req;
    logic [ZW-1:0] adc_ch;
    logic          adc_done;
    logic [AW-1:0] adc_data;
    logic [AW-1:0] th_low;
    logic [AW-1:0] th_high;
    logic [NZ-1:0] pump_en;
    logic [NZ-1:0] fault;
    logic          busy;
    logic          scan_done;

    int checks   = 0;
    int failures = 0;

    logic [NZ-1:0] m_pump;
    logic [NZ-1:0] m_fault;

    soil_moisture_scan_ctrl #(
        .N_ZONES(NZ), .ADC_W(AW), .ADC_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .adc_req(adc_req), .adc_ch(adc_ch),
        .adc_done(adc_done), .adc_data(adc_data),
        .th_low(th_low), .th_high(th_high),
        .pump_en(pump_en), .fault(fault),
        .busy(busy), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference pump rule applied to one captured sample.
    function automatic logic pump_rule(input logic [AW-1:0] s, input logic prev);
`ifdef MOISTURE_HYST_EN
        if (s < th_low) return 1'b1;
        if (s >= th_high) return 1'b0;
        return prev;
`else
        if (prev === 1'bx) return 1'b0;
        return (s < th_low);
`endif
    endfunction

    // d[z] = MEASURE cycles before the one carrying adc_done; d[z] >= TO means never.
    task automatic run_scan(input int d[NZ], input logic [AW-1:0] s[NZ],
                            input bit hold_start, input string tag);
        int  lat_exp = 1;
        int  cnt = 0;
        int  w = 0;
        int  cur = 0;
        int  reqs = 0;
        int  idle_bad = 0;
        bit  tracking = 0;
        bit  done_seen = 0;
        for (int z = 0; z < NZ; z++) begin
            if (d[z] < TO) begin
                m_pump[z]  = pump_rule(s[z], m_pump[z]);
                m_fault[z] = 1'b0;
                lat_exp   += d[z] + 2;
            end else begin
                m_pump[z]  = 1'b0;
                m_fault[z] = 1'b1;
                lat_exp   += TO;
            end
        end
        @(negedge clk);
        start    = 1'b1;
        adc_done = 1'b0;
        @(posedge clk);
        while (!done_seen && cnt < 2000) begin
            @(negedge clk);
            cnt++;
            start = hold_start && (cnt < lat_exp - 1);
            if (scan_done) begin
                done_seen = 1;
                adc_done  = 1'b0;
            end else begin
                if (adc_req) begin
                    reqs++;
                    tracking = 1;
                    w = 0;
                    cur = int'(adc_ch);
                end
                if (tracking) begin
                    adc_done = (w == d[cur]);
                    adc_data = adc_done ? s[cur] : AW'($urandom);
                    if (adc_done) tracking = 0;
                    w++;
                end else begin
                    adc_done = 1'($urandom_range(0, 1));
                    adc_data = AW'($urandom);
                end
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        check({tag, "_latency"},   32'(cnt),       32'(lat_exp));
        check({tag, "_reqs"},      32'(reqs),      32'(NZ));
        check({tag, "_pump"},      32'(pump_en),   32'(m_pump));
        check({tag, "_fault"},     32'(fault),     32'(m_fault));
        check({tag, "_busy_end"},  32'(busy),      32'd0);
        for (int i = 0; i < 3; i++) begin
            adc_done = 1'($urandom_range(0, 1));
            adc_data = AW'($urandom);
            @(negedge clk);
            if (adc_req !== 1'b0 || busy !== 1'b0 || scan_done !== 1'b0) idle_bad++;
        end
        adc_done = 1'b0;
        check({tag, "_idle_quiet"}, 32'(idle_bad), 32'd0);
    endtask

    int            dz[NZ];
    logic [AW-1:0] sz[NZ];
    int            guard;
    logic [2:0]    hyst_exp;

    initial begin
        rst = 1'b1; start = 1'b0; adc_done = 1'b0; adc_data = '0;
        th_low = 10'd300; th_high = 10'd600;
        m_pump = '0; m_fault = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_pump",      32'(pump_en),   32'd0);
        check("rst_fault",     32'(fault),     32'd0);
        check("rst_adc_req",   32'(adc_req),   32'd0);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("no_scan_without_start", 32'(busy), 32'd0);

        // Directed four-zone scan with minimum latency.
        run_scan('{0, 0, 0, 0}, '{10'd100, 10'd500, 10'd299, 10'd300}, 1'b0, "basic");
        check("basic_pump_0101", 32'(pump_en), 32'h5);

        // Zone 1 never answers.
        run_scan('{0, TO, 0, 0}, '{10'd100, 10'd100, 10'd100, 10'd700}, 1'b0, "timeout_z1");
        check("timeout_fault_0010", 32'(fault), 32'h2);

        // Done coincident with the timeout cycle on zone 2; start held high.
        run_scan('{0, 0, TO - 1, 1}, '{10'd100, 10'd100, 10'd50, 10'd100}, 1'b1, "coincide");
        check("coincide_fault_clear", 32'(fault), 32'h0);

        // Timeout on the last zone still ends the scan.
        run_scan('{1, 2, 0, TO + 3}, '{10'd900, 10'd0, 10'd299, 10'd5}, 1'b0, "timeout_last");

        // Threshold behaviour for zone 0 over three scans.
`ifdef MOISTURE_HYST_EN
        hyst_exp = 3'b011;
`else
        hyst_exp = 3'b001;
`endif
        th_low = 10'd300; th_high = 10'd600;
        run_scan('{0, 0, 0, 0}, '{10'd200, 10'd700, 10'd700, 10'd700}, 1'b0, "hyst_a");
        check("hyst_a_pump0", 32'(pump_en[0]), 32'(hyst_exp[0]));
        run_scan('{0, 0, 0, 0}, '{10'd450, 10'd700, 10'd700, 10'd700}, 1'b0, "hyst_b");
        check("hyst_b_pump0", 32'(pump_en[0]), 32'(hyst_exp[1]));
        run_scan('{0, 0, 0, 0}, '{10'd650, 10'd700, 10'd700, 10'd700}, 1'b0, "hyst_c");
        check("hyst_c_pump0", 32'(pump_en[0]), 32'(hyst_exp[2]));

        // Randomized scans.
        for (int r = 0; r < 12; r++) begin
            th_low  = AW'($urandom);
            th_high = AW'($urandom);
            for (int z = 0; z < NZ; z++) begin
                dz[z] = $urandom_range(0, TO + 1);
                sz[z] = AW'($urandom);
            end
            run_scan(dz, sz, 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
        end

        // Reset in the middle of a scan while zone 2 is being measured.
        @(negedge clk);
        start = 1'b1;
        guard = 0;
        @(negedge clk);
        start = 1'b0;
        while (!(adc_req && adc_ch == 2'd2) && guard < 200) begin
            adc_done = adc_req;
            adc_data = 10'd10;
            @(negedge clk);
            guard++;
        end
        check("midrst_reached_z2", 32'(guard < 200), 32'd1);
        adc_done = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("midrst_busy",    32'(busy),    32'd0);
        check("midrst_pump",    32'(pump_en), 32'd0);
        check("midrst_fault",   32'(fault),   32'd0);
        check("midrst_adc_req", 32'(adc_req), 32'd0);
        rst = 1'b0;
        start = 1'b0;
        m_pump = '0;
        m_fault = '0;
        repeat (4) @(negedge clk);
        check("midrst_needs_start", 32'(busy), 32'd0);

        th_low = 10'd300; th_high = 10'd600;
        run_scan('{0, 2, TO, 0}, '{10'd299, 10'd301, 10'd0, 10'd0}, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
